// File: rtl/tc_sram_tiled_if.sv
// Request/response bundle for tc_sram_tiled: per-port request, grant and read-return lanes.
// Combinational grant; the requester holds req/payload until granted.
interface tc_sram_tiled_if #(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned AddrWidth = 11,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned BeWidth   = 4
) ();
    logic                                 init_done_o;
    logic [NumPorts-1:0]                  req_i;
    logic [NumPorts-1:0]                  gnt_o;
    logic [NumPorts-1:0]                  we_i;
    logic [NumPorts-1:0][AddrWidth-1:0]   addr_i;
    logic [NumPorts-1:0][DataWidth-1:0]   wdata_i;
    logic [NumPorts-1:0][BeWidth-1:0]     be_i;
    logic [NumPorts-1:0][DataWidth-1:0]   rdata_o;
    logic [NumPorts-1:0]                  rvalid_o;

    modport master (
        input  init_done_o, gnt_o, rdata_o, rvalid_o,
        output req_i, we_i, addr_i, wdata_i, be_i
    );

    modport slave (
        output init_done_o, gnt_o, rdata_o, rvalid_o,
        input  req_i, we_i, addr_i, wdata_i, be_i
    );
endinterface

// File: rtl/tc_sram_tiled.sv
// Purpose: NumWords x DataWidth memory tiled from single-port macros, 1-2 ports, bank arbitration, zero-init.
// Latency: read data Latency (1 or 2) cycles after grant; writes land at the grant edge.
// Backpressure: gnt_o withheld during init and from the losing port of a same-bank conflict.

// Behavioural stand-in for the hard macro: active-low enables, bit-masked write, registered read.
module gf180mcu_sram_wrapper #(
    parameter int unsigned Words = 512,
    parameter int unsigned Width = 32
) (
    input  logic                     clk,
    input  logic                     cen,
    input  logic                     gwen,
    input  logic [Width-1:0]         wen,
    input  logic [$clog2(Words)-1:0] a,
    input  logic [Width-1:0]         d,
    output logic [Width-1:0]         q
);
    logic [Width-1:0] mem [Words];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!gwen) mem[a] <= (mem[a] & wen) | (d & ~wen);
            else       q      <= mem[a];
        end
    end
endmodule

module tc_sram_tiled #(
    parameter int unsigned NumWords   = 2048,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ByteWidth  = 8,
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned Latency    = 1,
    parameter int unsigned MacroWords = 512,
    parameter int unsigned MacroWidth = 32,
    parameter bit          InitZero   = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    tc_sram_tiled_if.slave bus
);
    localparam int unsigned NumBanks  = NumWords / MacroWords;
    localparam int unsigned NumCols   = (DataWidth + MacroWidth - 1) / MacroWidth;
    localparam int unsigned AddrWidth = $clog2(NumWords);
    localparam int unsigned RowWidth  = $clog2(MacroWords);
    localparam int unsigned BankWidth = (AddrWidth > RowWidth) ? AddrWidth - RowWidth : 1;
    localparam int unsigned PadWidth  = NumCols * MacroWidth;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    state_e                              state_q, state_d;
    logic [RowWidth-1:0]                 init_cnt_q, init_cnt_d;
    logic                                prio_q;
    logic                                conflict;
    logic [NumPorts-1:0]                 gnt;
    logic [NumPorts-1:0][BankWidth-1:0]  bank;
    logic [NumPorts-1:0][RowWidth-1:0]   row;
    logic [NumPorts-1:0][DataWidth-1:0]  mask;
    logic [NumPorts-1:0][PadWidth-1:0]   wpad, mpad;
    logic [NumBanks-1:0][PadWidth-1:0]   bank_q;
    logic [NumPorts-1:0]                 rd_vld_q;
    logic [NumPorts-1:0][BankWidth-1:0]  rd_bank_q;
    logic [NumPorts-1:0][DataWidth-1:0]  rd_data;

    // Decode; banks at or above NumBanks match no macro, so such writes vanish and reads return 0.
    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            bank[p] = BankWidth'(bus.addr_i[p] >> RowWidth);
            row[p]  = bus.addr_i[p][RowWidth-1:0];
            mask[p] = '0;
            for (int b = 0; b < DataWidth; b++) mask[p][b] = bus.be_i[p][b / ByteWidth];
            wpad[p] = PadWidth'(bus.wdata_i[p]);
            mpad[p] = PadWidth'(mask[p]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= InitZero ? ST_INIT : ST_RUN;
            init_cnt_q <= '0;
            prio_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            if (conflict) prio_q <= ~prio_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        gnt        = '0;
        conflict   = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == RowWidth'(MacroWords - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                gnt = bus.req_i;
                if (NumPorts == 2 && (&bus.req_i) && bank[0] == bank[NumPorts-1]) begin
                    conflict     = 1'b1;
                    gnt          = '0;
                    gnt[prio_q]  = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.gnt_o       = gnt;
    assign bus.init_done_o = (state_q == ST_RUN);

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic                cen, gwen;
        logic [RowWidth-1:0] a;
        logic [PadWidth-1:0] d, wen, q;

        // Arbitration leaves at most one granted port per bank.
        always_comb begin
            cen  = 1'b1;
            gwen = 1'b1;
            a    = '0;
            d    = '0;
            wen  = '1;
            if (state_q == ST_INIT) begin
                cen  = 1'b0;
                gwen = 1'b0;
                a    = init_cnt_q;
                wen  = '0;
            end else begin
                for (int p = 0; p < NumPorts; p++) begin
                    if (gnt[p] && bank[p] == BankWidth'(b)) begin
                        cen  = 1'b0;
                        gwen = ~bus.we_i[p];
                        a    = row[p];
                        d    = wpad[p];
                        wen  = ~mpad[p];
                    end
                end
            end
        end

        for (genvar c = 0; c < NumCols; c++) begin : g_col
            gf180mcu_sram_wrapper #(
                .Words (MacroWords),
                .Width (MacroWidth)
            ) u_macro (
                .clk  (clk_i),
                .cen  (cen),
                .gwen (gwen),
                .wen  (wen[c*MacroWidth +: MacroWidth]),
                .a    (a),
                .d    (d[c*MacroWidth +: MacroWidth]),
                .q    (q[c*MacroWidth +: MacroWidth])
            );
        end

        assign bank_q[b] = q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_vld_q  <= '0;
            rd_bank_q <= '0;
        end else begin
            rd_vld_q  <= gnt & ~bus.we_i;
            rd_bank_q <= bank;
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            rd_data[p] = '0;
            for (int b = 0; b < NumBanks; b++) begin
                if (rd_vld_q[p] && rd_bank_q[p] == BankWidth'(b)) rd_data[p] = bank_q[b][DataWidth-1:0];
            end
        end
    end

    if (Latency == 2) begin : g_lat2
        logic [NumPorts-1:0]                rvalid_q2;
        logic [NumPorts-1:0][DataWidth-1:0] rdata_q2;

        // Data register only loads on a valid read so the last value is held between reads.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rvalid_q2 <= '0;
                rdata_q2  <= '0;
            end else begin
                rvalid_q2 <= rd_vld_q;
                for (int p = 0; p < NumPorts; p++) begin
                    if (rd_vld_q[p]) rdata_q2[p] <= rd_data[p];
                end
            end
        end

        assign bus.rvalid_o = rvalid_q2;
        assign bus.rdata_o  = rdata_q2;
    end else begin : g_lat1
        assign bus.rvalid_o = rd_vld_q;
        assign bus.rdata_o  = rd_data;
    end
endmodule

// File: tb/tb_tc_sram_tiled.sv
// Bench for tc_sram_tiled: default 2048x32 Latency-1 instance plus a 1536-word Latency-2 instance.
module tb_tc_sram_tiled;
    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tc_sram_tiled_if #(.NumPorts(2), .AddrWidth(11), .DataWidth(32), .BeWidth(4)) if0 ();
    tc_sram_tiled_if #(.NumPorts(2), .AddrWidth(11), .DataWidth(32), .BeWidth(4)) if1 ();

    tc_sram_tiled u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
    tc_sram_tiled #(.NumWords(1536), .Latency(2)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));

    // Fields: req, we, a0, a1, d0, d1, be0, be1, gnt (this cycle), rv/chk/r0/r1 (after the next edge)
    typedef struct {
        logic [1:0]  req, we;
        logic [10:0] a0, a1;
        logic [31:0] d0, d1;
        logic [3:0]  be0, be1;
        logic [1:0]  gnt, rv, chk;
        logic [31:0] r0, r1;
    } vec_t;

    vec_t t0 [16];
    vec_t t1 [11];
    vec_t t2 [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input vec_t v);
        if (!sel) begin
            if0.req_i = v.req; if0.we_i = v.we;
            if0.addr_i[0] = v.a0; if0.addr_i[1] = v.a1;
            if0.wdata_i[0] = v.d0; if0.wdata_i[1] = v.d1;
            if0.be_i[0] = v.be0; if0.be_i[1] = v.be1;
        end else begin
            if1.req_i = v.req; if1.we_i = v.we;
            if1.addr_i[0] = v.a0; if1.addr_i[1] = v.a1;
            if1.wdata_i[0] = v.d0; if1.wdata_i[1] = v.d1;
            if1.be_i[0] = v.be0; if1.be_i[1] = v.be1;
        end
    endtask

    task automatic apply(input bit sel, input vec_t v, input string tag);
        logic [1:0]  g, rv;
        logic [31:0] r0, r1;
        drive(sel, v);
        #1;
        g = sel ? if1.gnt_o : if0.gnt_o;
        chk({tag, ".gnt"}, 32'(g), 32'(v.gnt));
        @(posedge clk);
        #1;
        rv = sel ? if1.rvalid_o : if0.rvalid_o;
        r0 = sel ? if1.rdata_o[0] : if0.rdata_o[0];
        r1 = sel ? if1.rdata_o[1] : if0.rdata_o[1];
        chk({tag, ".rvalid"}, 32'(rv), 32'(v.rv));
        if (v.chk[0]) chk({tag, ".rdata0"}, r0, v.r0);
        if (v.chk[1]) chk({tag, ".rdata1"}, r1, v.r1);
    endtask

    task automatic idle_all();
        vec_t z;
        z = '{2'b00, 2'b00, 11'd0, 11'd0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0};
        drive(1'b0, z);
        drive(1'b1, z);
    endtask

    task automatic wait_init(output int n);
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk);
            #1;
            if (if0.init_done_o) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        // Default instance, prio starts at 0.
        t0[0]  = '{2'b01, 2'b01, 11'd5,   11'd0,    32'hDEADBEEF, 32'h0,        4'hF, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
        t0[1]  = '{2'b01, 2'b01, 11'd5,   11'd0,    32'h00000011, 32'h0,        4'h1, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
        t0[2]  = '{2'b01, 2'b00, 11'd5,   11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b01, 32'hDEADBE11, 32'h0};
        t0[3]  = '{2'b11, 2'b11, 11'd10,  11'd600,  32'h12345678, 32'hCAFEF00D, 4'hF, 4'hF, 2'b11, 2'b00, 2'b00, 32'h0,        32'h0};
        t0[4]  = '{2'b11, 2'b00, 11'd10,  11'd600,  32'h0,        32'h0,        4'h0, 4'h0, 2'b11, 2'b11, 2'b11, 32'h12345678, 32'hCAFEF00D};
        t0[5]  = '{2'b10, 2'b10, 11'd0,   11'd600,  32'h0,        32'h11223344, 4'h0, 4'hA, 2'b10, 2'b00, 2'b00, 32'h0,        32'h0};
        t0[6]  = '{2'b10, 2'b00, 11'd0,   11'd600,  32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 2'b10, 32'h0,        32'h11FE330D};
        t0[7]  = '{2'b11, 2'b00, 11'd3,   11'd7,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b01, 32'h0,        32'h0};
        t0[8]  = '{2'b10, 2'b00, 11'd3,   11'd7,    32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 2'b10, 32'h0,        32'h0};
        t0[9]  = '{2'b11, 2'b00, 11'd3,   11'd7,    32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 2'b10, 32'h0,        32'h0};
        t0[10] = '{2'b01, 2'b00, 11'd3,   11'd7,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b01, 32'h0,        32'h0};
        t0[11] = '{2'b11, 2'b11, 11'd20,  11'd20,   32'hAAAAAAAA, 32'hBBBBBBBB, 4'hF, 4'hF, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
        t0[12] = '{2'b10, 2'b10, 11'd20,  11'd20,   32'hAAAAAAAA, 32'hBBBBBBBB, 4'hF, 4'hF, 2'b10, 2'b00, 2'b00, 32'h0,        32'h0};
        t0[13] = '{2'b01, 2'b00, 11'd20,  11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b01, 32'hBBBBBBBB, 32'h0};
        t0[14] = '{2'b10, 2'b00, 11'd0,   11'd1234, 32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 2'b10, 32'h0,        32'h0};
        t0[15] = '{2'b00, 2'b00, 11'd0,   11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0};
        // Latency-2 instance with three banks; addresses >= 1536 are out of range.
        t1[0]  = '{2'b01, 2'b01, 11'd100,  11'd0,    32'h5A5A5A5A, 32'h0,        4'hF, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
        t1[1]  = '{2'b01, 2'b00, 11'd100,  11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0};
        t1[2]  = '{2'b01, 2'b00, 11'd1800, 11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b01, 32'h5A5A5A5A, 32'h0};
        t1[3]  = '{2'b00, 2'b00, 11'd0,    11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b01, 2'b01, 32'h0,        32'h0};
        t1[4]  = '{2'b00, 2'b00, 11'd0,    11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b01, 32'h0,        32'h0};
        t1[5]  = '{2'b01, 2'b00, 11'd100,  11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b00, 2'b01, 32'h0,        32'h0};
        t1[6]  = '{2'b10, 2'b10, 11'd0,    11'd1600, 32'h0,        32'hFFFFFFFF, 4'h0, 4'hF, 2'b10, 2'b01, 2'b01, 32'h5A5A5A5A, 32'h0};
        t1[7]  = '{2'b00, 2'b00, 11'd0,    11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b01, 32'h5A5A5A5A, 32'h0};
        t1[8]  = '{2'b10, 2'b00, 11'd0,    11'd64,   32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b00, 2'b01, 32'h5A5A5A5A, 32'h0};
        t1[9]  = '{2'b00, 2'b00, 11'd0,    11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b10, 2'b10, 32'h0,        32'h0};
        t1[10] = '{2'b00, 2'b00, 11'd0,    11'd0,    32'h0,        32'h0,        4'h0, 4'h0, 2'b00, 2'b00, 2'b01, 32'h5A5A5A5A, 32'h0};
        // After a second reset: memory re-zeroed and prio back to port 0.
        t2[0]  = '{2'b11, 2'b00, 11'd5,   11'd7,    32'h0,        32'h0,        4'h0, 4'h0, 2'b01, 2'b01, 2'b01, 32'h0,        32'h0};
        t2[1]  = '{2'b10, 2'b00, 11'd5,   11'd7,    32'h0,        32'h0,        4'h0, 4'h0, 2'b10, 2'b10, 2'b10, 32'h0,        32'h0};

        rst_n = 1'b0;
        idle_all();
        if0.req_i = 2'b11;
        if1.req_i = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.gnt0",       32'(if0.gnt_o),       32'h0);
        chk("reset.gnt1",       32'(if1.gnt_o),       32'h0);
        chk("reset.rvalid0",    32'(if0.rvalid_o),    32'h0);
        chk("reset.rvalid1",    32'(if1.rvalid_o),    32'h0);
        chk("reset.rdata1",     if1.rdata_o[0],       32'h0);
        chk("reset.init_done0", 32'(if0.init_done_o), 32'h0);
        chk("reset.init_done1", 32'(if1.init_done_o), 32'h0);

        idle_all();
        @(negedge clk) rst_n = 1'b1;
        wait_init(n);
        chk("init.cycles", 32'(n), 32'd512);
        chk("init.done1",  32'(if1.init_done_o), 32'h1);

        for (int i = 0; i < 16; i++) apply(1'b0, t0[i], $sformatf("d0.v%0d", i));
        for (int i = 0; i < 11; i++) apply(1'b1, t1[i], $sformatf("d1.v%0d", i));

        // Abort init part-way through and check the full sequence reruns.
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midinit.done_low", 32'(if0.init_done_o), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_init(n);
        chk("reinit.cycles", 32'(n), 32'd512);
        for (int i = 0; i < 2; i++) apply(1'b0, t2[i], $sformatf("d0.r%0d", i));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
